// File: rtl/mm_sched_pkg.sv
// rtl/mm_sched_pkg.sv - shared types and constants for the matrix-multiply job scheduler
package mm_sched_pkg;

    localparam int DW = 20;

    localparam logic [1:0] HDR_ROW1 = 2'd0;
    localparam logic [1:0] HDR_COL1 = 2'd1;
    localparam logic [1:0] HDR_COL2 = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG0 = 3'd1,
        CFG1 = 3'd2,
        CFG2 = 3'd3,
        RUN  = 3'd4,
        DONE = 3'd5
    } state_t;

    typedef struct packed {
        logic [DW-1:0] row1;
        logic [DW-1:0] col1;
        logic [DW-1:0] col2;
        logic [3:0]    id;
    } job_t;

    // A job with any zero dimension is rejected without touching the engine
    function automatic logic has_zero_dim(input job_t j);
        return (j.row1 == '0) || (j.col1 == '0) || (j.col2 == '0);
    endfunction

endpackage

// File: rtl/mm_job_fifo.sv
// rtl/mm_job_fifo.sv - synchronous FIFO of job descriptors
module mm_job_fifo
    import mm_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  job_t                     i_data,
    input  logic                     i_pop,
    output job_t                     o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    job_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    // Full/empty come from the registered count only, so a pop never
    // frees a slot for a push in the same cycle.
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Descriptor storage; occupancy gates every read so no reset is needed
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// rtl/mm_job_scheduler.sv - queues jobs, writes engine headers, runs engine with timeout
module mm_job_scheduler
    import mm_sched_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CW      = 32,
    parameter int TIMEOUT = 1000000
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_job_valid,
    output logic                     o_job_ready,
    input  logic [DW-1:0]            i_job_row1,
    input  logic [DW-1:0]            i_job_col1,
    input  logic [DW-1:0]            i_job_col2,
    input  logic [3:0]               i_job_id,
    output logic                     o_cfg_we,
    output logic [1:0]               o_cfg_addr,
    output logic [DW-1:0]            o_cfg_data,
    output logic                     o_mm_reset,
    input  logic                     i_mm_finish,
    output logic                     o_done_valid,
    output logic [3:0]               o_done_id,
    output logic [CW-1:0]            o_done_cycles,
    output logic                     o_done_timeout,
    output logic                     o_done_err,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_pending
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_t          r_state;
    job_t            r_job;
    logic [CW-1:0]   r_cnt;
    logic            r_cfg_we;
    logic [1:0]      r_cfg_addr;
    logic [DW-1:0]   r_cfg_data;
    logic            r_mm_reset;
    logic            r_done_valid;
    logic [3:0]      r_done_id;
    logic [CW-1:0]   r_done_cycles;
    logic            r_done_timeout;
    logic            r_done_err;

    job_t            w_in_job;
    job_t            w_head;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;

    assign w_in_job = '{row1: i_job_row1, col1: i_job_col1, col2: i_job_col2, id: i_job_id};
    assign w_pop    = (r_state == IDLE) && !w_empty;

    mm_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_job_valid),
        .i_data  (w_in_job),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (o_pending),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign o_job_ready    = !w_full;
    assign o_busy         = (r_state != IDLE);
    assign o_cfg_we       = r_cfg_we;
    assign o_cfg_addr     = r_cfg_addr;
    assign o_cfg_data     = r_cfg_data;
    assign o_mm_reset     = r_mm_reset;
    assign o_done_valid   = r_done_valid;
    assign o_done_id      = r_done_id;
    assign o_done_cycles  = r_done_cycles;
    assign o_done_timeout = r_done_timeout;
    assign o_done_err     = r_done_err;

    // Job sequencer: pop, header writes, engine run with timeout, completion report
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_job          <= '0;
            r_cnt          <= '0;
            r_cfg_we       <= 1'b0;
            r_cfg_addr     <= '0;
            r_cfg_data     <= '0;
            r_mm_reset     <= 1'b1;
            r_done_valid   <= 1'b0;
            r_done_id      <= '0;
            r_done_cycles  <= '0;
            r_done_timeout <= 1'b0;
            r_done_err     <= 1'b0;
        end else begin
            r_cfg_we     <= 1'b0;
            r_done_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_job <= w_head;
                        if (has_zero_dim(w_head)) begin
                            r_state        <= DONE;
                            r_done_valid   <= 1'b1;
                            r_done_id      <= w_head.id;
                            r_done_cycles  <= '0;
                            r_done_timeout <= 1'b0;
                            r_done_err     <= 1'b1;
                        end else begin
                            r_state    <= CFG0;
                            r_cfg_we   <= 1'b1;
                            r_cfg_addr <= HDR_ROW1;
                            r_cfg_data <= w_head.row1;
                        end
                    end
                end
                CFG0: begin
                    r_state    <= CFG1;
                    r_cfg_we   <= 1'b1;
                    r_cfg_addr <= HDR_COL1;
                    r_cfg_data <= r_job.col1;
                end
                CFG1: begin
                    r_state    <= CFG2;
                    r_cfg_we   <= 1'b1;
                    r_cfg_addr <= HDR_COL2;
                    r_cfg_data <= r_job.col2;
                end
                CFG2: begin
                    r_state    <= RUN;
                    r_mm_reset <= 1'b0;
                    r_cnt      <= CW'(1);
                end
                RUN: begin
                    // r_cnt == 1 marks the first RUN cycle, where the engine is
                    // still leaving reset and its finish flag is meaningless.
                    if (i_mm_finish && (r_cnt != CW'(1))) begin
                        r_state        <= DONE;
                        r_mm_reset     <= 1'b1;
                        r_done_valid   <= 1'b1;
                        r_done_id      <= r_job.id;
                        r_done_cycles  <= r_cnt;
                        r_done_timeout <= 1'b0;
                        r_done_err     <= 1'b0;
                    end else if (r_cnt >= TIMEOUT_C) begin
                        r_state        <= DONE;
                        r_mm_reset     <= 1'b1;
                        r_done_valid   <= 1'b1;
                        r_done_id      <= r_job.id;
                        r_done_cycles  <= TIMEOUT_C;
                        r_done_timeout <= 1'b1;
                        r_done_err     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_mm_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
